// File: rtl/mod_arbiter.sv
// mod_arbiter: round-robin modulator arbiter with bursts, retune gap and downstream credits.
// Define ARB_STATS_EN to add per-requester grant/packet counters and a grant-end $display.
module mod_arbiter #(
   parameter int N_REQ      = 4,
   parameter int MAX_BURST  = 4,
   parameter int SWITCH_GAP = 2,
   parameter int CREDITS    = 8,
   parameter int DATA_W     = 8
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [N_REQ-1:0][DATA_W-1:0]   req_data_i,
   input  logic [N_REQ-1:0]               req_valid_i,
   output logic [N_REQ-1:0]               req_ready_o,
   output logic [DATA_W-1:0]              mod_data_o,
   output logic                           mod_valid_o,
   input  logic                           credit_return_i,
   output logic [$clog2(N_REQ)-1:0]       grant_id_o,
   output logic                           busy_o,
   output logic                           credit_err_o
);
   localparam int GW = $clog2(N_REQ);
   localparam int CW = $clog2(CREDITS + 1);
   localparam int BW = $clog2(MAX_BURST + 1);
   localparam int PW = (SWITCH_GAP > 1) ? $clog2(SWITCH_GAP) : 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SEND = 2'd1;
   localparam logic [1:0] GAP  = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [GW-1:0]     rr_ptr_q, rr_ptr_d, grant_q, grant_d, win, idx;
   logic [BW-1:0]     burst_cnt_q, burst_cnt_d;
   logic [PW-1:0]     gap_cnt_q, gap_cnt_d;
   logic [CW-1:0]     credit_cnt_q, credit_cnt_d;
   logic [DATA_W-1:0] mod_data_q, mod_data_d;
   logic              mod_valid_q, mod_valid_d, credit_err_q, credit_err_d;
   logic              has_credit, full, xfer, grant_end;

   assign has_credit = credit_cnt_q != '0;
   assign full       = credit_cnt_q == CW'(CREDITS);
   assign xfer       = (state_q == SEND) && req_valid_i[grant_q] && has_credit;
   assign grant_end  = (state_q == SEND) &&
                       (!req_valid_i[grant_q] || (xfer && burst_cnt_q == BW'(MAX_BURST - 1)));

   assign req_ready_o  = (state_q == SEND && has_credit) ? (N_REQ'(1) << grant_q) : '0;
   assign mod_data_o   = mod_data_q;
   assign mod_valid_o  = mod_valid_q;
   assign grant_id_o   = grant_q;
   assign busy_o       = state_q != IDLE;
   assign credit_err_o = credit_err_q;

   // Scan from farthest to nearest offset so the requester closest to rr_ptr wins.
   always_comb begin
      win = rr_ptr_q;
      idx = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = GW'((int'(rr_ptr_q) + k) % N_REQ);
         if (req_valid_i[idx]) win = idx;
      end
   end

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      grant_d      = grant_q;
      burst_cnt_d  = xfer ? burst_cnt_q + BW'(1) : burst_cnt_q;
      gap_cnt_d    = gap_cnt_q;
      mod_valid_d  = xfer;
      mod_data_d   = xfer ? req_data_i[grant_q] : mod_data_q;
      credit_cnt_d = (xfer && !credit_return_i)         ? credit_cnt_q - CW'(1) :
                     (!xfer && credit_return_i && !full) ? credit_cnt_q + CW'(1) : credit_cnt_q;
      credit_err_d = credit_err_q | (credit_return_i && !xfer && full);
      if (state_q == IDLE && |req_valid_i && has_credit) begin
         state_d     = SEND;
         grant_d     = win;
         burst_cnt_d = '0;
      end
      if (grant_end) begin
         rr_ptr_d  = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
         state_d   = (SWITCH_GAP > 0) ? GAP : IDLE;
         gap_cnt_d = '0;
      end
      if (state_q == GAP) begin
         gap_cnt_d = gap_cnt_q + PW'(1);
         if (gap_cnt_q == PW'(SWITCH_GAP - 1)) state_d = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         grant_q      <= '0;
         burst_cnt_q  <= '0;
         gap_cnt_q    <= '0;
         credit_cnt_q <= CW'(CREDITS);
         mod_valid_q  <= 1'b0;
         mod_data_q   <= '0;
         credit_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         grant_q      <= grant_d;
         burst_cnt_q  <= burst_cnt_d;
         gap_cnt_q    <= gap_cnt_d;
         credit_cnt_q <= credit_cnt_d;
         mod_valid_q  <= mod_valid_d;
         mod_data_q   <= mod_data_d;
         credit_err_q <= credit_err_d;
      end
   end

`ifdef ARB_STATS_EN
   logic [31:0] grant_count [N_REQ];
   logic [31:0] pkt_count   [N_REQ];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < N_REQ; i++) begin
            grant_count[i] <= '0;
            pkt_count[i]   <= '0;
         end
      end else begin
         if (state_q == IDLE && state_d == SEND) grant_count[grant_d] <= grant_count[grant_d] + 32'd1;
         if (xfer) pkt_count[grant_q] <= pkt_count[grant_q] + 32'd1;
         if (grant_end) $display("Arbiter grant %0d burst %0d", grant_q, burst_cnt_d);
      end
   end
`else
`endif
endmodule

// File: tb/tb_mod_arbiter.sv
// tb_mod_arbiter: per-cycle vector table for burst/round-robin traces plus directed credit and reset sequences.
module tb_mod_arbiter;
   logic            clk = 1'b0;
   logic            rst;
   logic [3:0][7:0] req_data;
   logic [3:0]      req_valid, req_ready;
   logic [7:0]      mod_data;
   logic            mod_valid, credit_return, busy, credit_err;
   logic [1:0]      grant_id;
   int              n_cmp = 0;
   int              n_bad = 0;

   typedef struct {
      logic       rst;
      logic [3:0] vld;
      logic       cr;
      logic [3:0] rdy;
      logic       mv;
      logic [7:0] dat;
      logic [1:0] gid;
      logic       bsy;
   } vec_t;
   vec_t vq[$];

   always #5 clk = ~clk;

   mod_arbiter dut (
      .clk(clk), .rst(rst), .req_data_i(req_data), .req_valid_i(req_valid),
      .req_ready_o(req_ready), .mod_data_o(mod_data), .mod_valid_o(mod_valid),
      .credit_return_i(credit_return), .grant_id_o(grant_id), .busy_o(busy),
      .credit_err_o(credit_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_xfers(input int n, input int budget);
      int got = 0;
      int cyc = 0;
      while (got < n && cyc < budget) begin
         #1;
         if (|(req_valid & req_ready)) got++;
         tick;
         cyc++;
      end
      chk("xfer_count", got, n);
   endtask

   task automatic wait_idle(input int budget);
      int cyc = 0;
      while (busy && cyc < budget) begin
         tick;
         cyc++;
      end
      chk("idle_reached", busy, 0);
   endtask

   function automatic void add(input logic r, input logic [3:0] v, input logic c, input logic [3:0] rd,
                               input logic m, input logic [7:0] d, input logic [1:0] g, input logic b);
      vq.push_back('{rst: r, vld: v, cr: c, rdy: rd, mv: m, dat: d, gid: g, bsy: b});
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 4; i++) req_data[i] = 8'hA0 + 8'(i);
      rst = 1'b1; req_valid = '0; credit_return = 1'b0;
      tick; tick; #1;
      chk("rst_busy", busy, 0);
      chk("rst_mv", mod_valid, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_cerr", credit_err, 0);
      chk("rst_mdata", mod_data, 0);
      chk("rst_credit", dut.credit_cnt_q, 8);
      chk("rst_rr", dut.rr_ptr_q, 0);

      // Requester 0: 6 packets -> burst of 4, gap 2, idle 1, burst of 2.
      add(0, 4'h1, 0, 4'h0, 0, 8'h00, 0, 0);
      add(0, 4'h1, 0, 4'h1, 0, 8'h00, 0, 1);
      for (int i = 0; i < 3; i++) add(0, 4'h1, 0, 4'h1, 1, 8'hA0, 0, 1);
      add(0, 4'h1, 0, 4'h0, 1, 8'hA0, 0, 1);
      add(0, 4'h1, 0, 4'h0, 0, 8'h00, 0, 1);
      add(0, 4'h1, 0, 4'h0, 0, 8'h00, 0, 0);
      add(0, 4'h1, 0, 4'h1, 0, 8'h00, 0, 1);
      add(0, 4'h1, 0, 4'h1, 1, 8'hA0, 0, 1);
      add(0, 4'h0, 0, 4'h1, 1, 8'hA0, 0, 1);
      add(0, 4'h0, 0, 4'h0, 0, 8'h00, 0, 1);
      add(0, 4'h0, 0, 4'h0, 0, 8'h00, 0, 1);
      add(1, 4'h0, 0, 4'h0, 0, 8'h00, 0, 0);
      // Requesters 0 and 2 alternate; every issue carries a credit return.
      add(0, 4'h5, 0, 4'h0, 0, 8'h00, 0, 0);
      for (int b = 0; b < 4; b++) begin
         logic [1:0] g;
         logic [3:0] rd;
         logic [7:0] d;
         g  = (b % 2 == 0) ? 2'd0 : 2'd2;
         rd = (b % 2 == 0) ? 4'h1 : 4'h4;
         d  = (b % 2 == 0) ? 8'hA0 : 8'hA2;
         add(0, 4'h5, 1, rd, 0, 8'h00, g, 1);
         for (int i = 0; i < 3; i++) add(0, 4'h5, 1, rd, 1, d, g, 1);
         add(0, (b == 3) ? 4'h0 : 4'h5, 0, 4'h0, 1, d, g, 1);
         add(0, (b == 3) ? 4'h0 : 4'h5, 0, 4'h0, 0, 8'h00, g, 1);
         add(0, (b == 3) ? 4'h0 : 4'h5, 0, 4'h0, 0, 8'h00, g, 0);
      end

      foreach (vq[i]) begin
         rst = vq[i].rst; req_valid = vq[i].vld; credit_return = vq[i].cr;
         #1;
         chk($sformatf("v%0d_ready", i), req_ready, vq[i].rdy);
         chk($sformatf("v%0d_mv", i), mod_valid, vq[i].mv);
         if (vq[i].mv) chk($sformatf("v%0d_data", i), mod_data, vq[i].dat);
         chk($sformatf("v%0d_gid", i), grant_id, vq[i].gid);
         chk($sformatf("v%0d_busy", i), busy, vq[i].bsy);
         tick;
      end
      #1;
      chk("rr_credit_kept", dut.credit_cnt_q, 8);
      chk("rr_cerr", credit_err, 0);

      // Credit exhaustion mid-burst and single-credit release.
      rst = 1'b1; tick; rst = 1'b0;
      req_valid = 4'h2;
      wait_xfers(6, 40);
      req_valid = 4'h0;
      wait_idle(10);
      chk("credit_after6", dut.credit_cnt_q, 2);
      req_valid = 4'h2;
      wait_xfers(2, 20);
      #1;
      chk("stall_ready", req_ready, 0);
      chk("stall_busy", busy, 1);
      tick; #1;
      chk("stall_ready2", req_ready, 0);
      chk("stall_mv", mod_valid, 0);
      credit_return = 1'b1;
      tick;
      credit_return = 1'b0;
      #1;
      chk("release_ready", req_ready, 4'h2);
      tick; #1;
      chk("release_mv", mod_valid, 1);
      chk("release_data", mod_data, 8'hA1);
      chk("restall_ready", req_ready, 0);
      tick; #1;
      chk("restall_mv", mod_valid, 0);
      req_valid = 4'h0;
      wait_idle(10);
      chk("credit_empty", dut.credit_cnt_q, 0);

      // Overflow return sets sticky error; issue + return in one cycle is neutral.
      rst = 1'b1; tick; rst = 1'b0;
      credit_return = 1'b1;
      tick;
      credit_return = 1'b0;
      #1;
      chk("ovf_cerr", credit_err, 1);
      chk("ovf_credit", dut.credit_cnt_q, 8);
      req_valid = 4'h1;
      wait_xfers(3, 20);
      chk("credit_five", dut.credit_cnt_q, 5);
      credit_return = 1'b1;
      tick;
      credit_return = 1'b0;
      #1;
      chk("same_cycle_credit", dut.credit_cnt_q, 5);
      chk("cerr_sticky", credit_err, 1);
      req_valid = 4'h0;
      wait_idle(10);

      // Reset in the middle of a burst.
      req_valid = 4'h1;
      wait_xfers(2, 20);
      rst = 1'b1;
      tick;
      rst = 1'b0; req_valid = 4'h0;
      #1;
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_mv", mod_valid, 0);
      chk("mid_rst_ready", req_ready, 0);
      chk("mid_rst_credit", dut.credit_cnt_q, 8);
      chk("mid_rst_cerr", credit_err, 0);

      // Requester 3 drops valid after 2 packets.
      req_valid = 4'h8;
      wait_xfers(2, 20);
      req_valid = 4'h0;
      #1;
      chk("drop_ready", req_ready, 4'h8);
      tick; #1;
      chk("drop_state_gap", dut.state_q, 2);
      chk("drop_busy", busy, 1);
      chk("drop_ready_gap", req_ready, 0);
      chk("drop_gid", grant_id, 3);
      chk("drop_rr", dut.rr_ptr_q, 0);
      chk("drop_mv", mod_valid, 0);
      wait_idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
